// File: rtl/data_mem_responder.sv
// Word-addressed data RAM that answers read/write requests after a fixed,
// parameterised number of clock edges, signalling completion with a one-cycle ready pulse.
module data_mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        RST,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state, state_next;
  logic [3:0]  cnt, cnt_next;
  logic        lat_we;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        enter_resp;
  logic        bad_addr;
  logic [AW-1:0] word_idx;

  logic [31:0] mem [DEPTH];

  assign word_idx = lat_addr[AW+1:2];
  assign bad_addr = (lat_addr[1:0] != 2'b00) || (lat_addr[31:2] >= 30'(DEPTH));
  assign busy     = (state != IDLE);

  // WAIT counts down from LATENCY-1; the response is taken on the edge where it reaches zero,
  // which places the ready pulse exactly LATENCY edges after acceptance.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    enter_resp = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          state_next = WAIT;
          cnt_next   = 4'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt == 4'd0) begin
          state_next = RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_next = cnt - 4'd1;
        end
      end
      RESP: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!RST) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      ready     <= 1'b0;
      err       <= 1'b0;
      rdata     <= 32'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (state == IDLE && req) begin
        lat_we    <= we;
        lat_addr  <= addr;
        lat_wdata <= wdata;
      end
      ready <= enter_resp;
      err   <= enter_resp && bad_addr;
      rdata <= (enter_resp && !lat_we && !bad_addr) ? mem[word_idx] : 32'd0;
    end
  end

  // RAM contents survive reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (RST && enter_resp && lat_we && !bad_addr) begin
      mem[word_idx] <= lat_wdata;
    end
  end

endmodule
